blink_sequencer: RTL

Command-driven LED blink controller that sequences a prescaled tick counter.
- Accepts a blink command over a valid/ready handshake: on-time, off-time, repeat count.
- Drives one LED through the requested pattern, then pulses done.
- Sits between the top-level control logic (buttons, AVR/serial command decode) and the board LEDs. It replaces free-running MSB blinking with a controlled, repeatable pattern.

---
 rtl/blink_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/blink_sequencer.sv
// Command-driven LED blink controller: latches on/off/count, walks ON/OFF phases
// on a free-running prescaled tick, then pulses done. abort cancels silently.
module blink_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int TW       = 8,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [TW-1:0] cmd_on,
    input  logic [TW-1:0] cmd_off,
    input  logic [CW-1:0] cmd_count,
    input  logic          abort,
    output logic          led,
    output logic          busy,
    output logic          done
);
    localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [TW-1:0] phase, phase_n;
    logic [TW-1:0] on_q, on_n;
    logic [TW-1:0] off_q, off_n;
    logic [CW-1:0] rem, rem_n;
    logic          done_n;
    logic          tick;
    logic          accept;

    assign cmd_ready = (state == IDLE) && !abort && rst;
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (presc == PS_MAX);

    always_comb begin
        state_n = state;
        presc_n = presc;
        phase_n = phase;
        rem_n   = rem;
        on_n    = on_q;
        off_n   = off_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    on_n    = cmd_on;
                    off_n   = cmd_off;
                    presc_n = '0;
                    if (cmd_count == '0 || cmd_on == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = ON;
                        phase_n = cmd_on;
                        rem_n   = cmd_count;
                    end
                end
            end
            ON: begin
                // prescaler keeps running across phase changes so total time never drifts
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (phase == TW'(1)) begin
                        rem_n = rem - CW'(1);
                        if (rem == CW'(1)) begin
                            state_n = IDLE;
                            phase_n = '0;
                            presc_n = '0;
                            done_n  = 1'b1;
                        end else if (off_q == '0) begin
                            phase_n = on_q;
                        end else begin
                            state_n = OFF;
                            phase_n = off_q;
                        end
                    end else begin
                        phase_n = phase - TW'(1);
                    end
                end
            end
            OFF: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (phase == TW'(1)) begin
                        state_n = ON;
                        phase_n = on_q;
                    end else begin
                        phase_n = phase - TW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // abort overrides a coincident completion: no done pulse
        if (abort && state != IDLE) begin
            state_n = IDLE;
            presc_n = '0;
            phase_n = '0;
            rem_n   = '0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            presc <= '0;
            phase <= '0;
            rem   <= '0;
            on_q  <= '0;
            off_q <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            phase <= phase_n;
            rem   <= rem_n;
            on_q  <= on_n;
            off_q <= off_n;
            led   <= (state_n == ON);
            busy  <= (state_n != IDLE);
            done  <= done_n;
        end
    end
endmodule
